// File: rtl/hypot_sched.sv
// hypot_sched -- round-robin scheduler in front of one shared iterative
// magnitude unit that computes floor(sqrt(x*x + y*y)), one result bit per cycle.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]      per-requester request valid
//   req_ready  [NREQ]      per-requester accept, one-hot or zero, only in IDLE
//   req_x      [NREQ*W]    packed x operands, requester i at [i*W +: W]
//   req_y      [NREQ*W]    packed y operands, same packing
//   rsp_valid  result valid, held in DONE until rsp_ready
//   rsp_ready  downstream accepts the result
//   rsp_data   [W+1]       floor(sqrt(x^2 + y^2))
//   rsp_id     [IDW]       index of the requester owning rsp_data
//   busy       high whenever the FSM is not in IDLE
module hypot_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int KW = $clog2(W + 1);
  localparam int SW = 2 * W + 2;  // trial square width, never truncated

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, grant_id, id_q;
  logic [NREQ-1:0] grant;
  logic            grant_found;
  logic [W-1:0]    x_q, y_q;
  logic [2*W:0]    sum_q, sum_calc;
  logic [W:0]      res_q, trial, res_nxt;
  logic [KW-1:0]   k_q;
  logic [SW-1:0]   trial_sq;
  logic [W:0]      rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  int              idx;

  // Round-robin search starting at rr_ptr. Held at zero during reset so
  // req_ready reads 0 while rst is high even though the state is IDLE.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    if (state == IDLE && !rst) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (int'(rr_ptr) + off) % NREQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = IDW'(idx);
        end
      end
    end
  end

  // One restoring-root step: keep bit k if the trial square still fits.
  always_comb begin
    sum_calc = (2*W+1)'(x_q) * (2*W+1)'(x_q) + (2*W+1)'(y_q) * (2*W+1)'(y_q);
    trial    = res_q | ((W+1)'(1) << k_q);
    trial_sq = SW'(trial) * SW'(trial);
    res_nxt  = (trial_sq <= SW'(sum_q)) ? trial : res_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = SQUARE;
      SQUARE:  state_nxt = ROOT;
      ROOT:    if (k_q == '0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sum_q      <= '0;
      res_q      <= '0;
      k_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            x_q    <= req_x[int'(grant_id)*W +: W];
            y_q    <= req_y[int'(grant_id)*W +: W];
            id_q   <= grant_id;
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        SQUARE: begin
          sum_q <= sum_calc;
          res_q <= '0;
          k_q   <= KW'(W);
        end
        ROOT: begin
          res_q <= res_nxt;
          if (k_q == '0) begin
            rsp_data_q <= res_nxt;
            rsp_id_q   <= id_q;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        default: ;  // DONE holds the response registers stable
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hypot_sched.sv
// tb_hypot_sched -- directed bench for hypot_sched (NREQ=4, W=8): reset state,
// latency, boundary results, round-robin order and spacing, backpressure,
// mid-operation reset and a randomised phase with a response scoreboard.
module tb_hypot_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  hypot_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int data;
    int id;
  } exp_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  int   acc_ids[$];
  time  acc_times[$];
  int   rsp_ids[$];
  logic [NREQ-1:0] acc_pending = '0;

  function automatic int isqrt(input int s);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observes handshakes just before the rising edge that completes them.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      exp_q.delete();
    end else begin
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{data: isqrt(int'(req_x[i*W +: W]) ** 2 + int'(req_y[i*W +: W]) ** 2), id: i});
          acc_ids.push_back(i);
          acc_times.push_back($time + 2);
          acc_pending[i] = 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data", 32'(rsp_data), e.data);
          check("sb_id", 32'(rsp_id), e.id);
        end
      end
    end
  end

  task automatic set_req(input int id, input int x, input int y);
    req_x[id*W +: W] = 8'(x);
    req_y[id*W +: W] = 8'(y);
    req_valid[id]    = 1'b1;
  endtask

  // Single requester transaction with rsp_ready low until the result shows.
  task automatic run_one(input int id, input int x, input int y, input int exp, input string tag);
    time t_acc;
    set_req(id, x, y);
    #1;
    for (int i = 0; i < 40 && !req_ready[id]; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    req_valid[id] = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    check({tag, "_latency"}, 32'(($time - t_acc - 5) / 10), 10);
    check({tag, "_data"}, 32'(rsp_data), exp);
    check({tag, "_id"}, 32'(rsp_id), id);
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    time t_acc;
    time t_rel;
    int  n0;

    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;

    // Reset values, with a request already pending.
    @(negedge clk);
    set_req(0, 3, 4);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);

    // 3,4 -> 5 with exact latency and busy window.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_grant", 32'(req_ready), 1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t1_busy", 32'(busy), 1);
      check("t1_no_valid_yet", 32'(rsp_valid), 0);
      @(negedge clk);
    end
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_latency", 32'(($time - t_acc - 5) / 10), 10);
    check("t1_data", 32'(rsp_data), 5);
    check("t1_id", 32'(rsp_id), 0);
    check("t1_busy_done", 32'(busy), 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_valid_drop", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;

    // Boundary operands.
    run_one(0, 0, 0, 0, "t2_zero");
    run_one(0, 255, 255, 360, "t2_max");
    run_one(0, 1, 1, 1, "t2_one");
    run_one(0, 0, 255, 255, "t2_edge");

    // All four requesting: order 0,1,2,3,0 at 12-cycle spacing.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_ids.delete();
    acc_times.delete();
    rsp_ids.delete();
    rsp_ready = 1'b1;
    set_req(0, 3, 4);
    set_req(1, 6, 8);
    set_req(2, 5, 12);
    set_req(3, 8, 15);
    for (int i = 0; i < 100 && acc_ids.size() < 5; i++) @(negedge clk);
    req_valid = '0;
    repeat (15) @(negedge clk);
    check("t3_accepts", 32'(acc_ids.size()), 5);
    if (acc_ids.size() >= 5) begin
      check("t3_grant0", 32'(acc_ids[0]), 0);
      check("t3_grant1", 32'(acc_ids[1]), 1);
      check("t3_grant2", 32'(acc_ids[2]), 2);
      check("t3_grant3", 32'(acc_ids[3]), 3);
      check("t3_grant4", 32'(acc_ids[4]), 0);
      for (int i = 1; i < 5; i++)
        check("t3_spacing", 32'(acc_times[i] - acc_times[i-1]), 120);
    end
    check("t3_responses", 32'(rsp_ids.size()), 5);

    // Backpressure: DONE holds, nobody granted, then grant right after release.
    rsp_ready = 1'b0;
    set_req(1, 7, 24);
    #1;
    check("t4_grant1", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(2, 9, 12);
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_data", 32'(rsp_data), 25);
      check("t4_hold_id", 32'(rsp_id), 1);
      check("t4_hold_ready", 32'(req_ready), 0);
      check("t4_hold_busy", 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    t_rel = $time;
    @(negedge clk);
    check("t4_idle_busy", 32'(busy), 0);
    check("t4_idle_valid", 32'(rsp_valid), 0);
    check("t4_idle_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    check("t4_next_id", 32'(acc_ids[$]), 2);
    check("t4_next_time", 32'(acc_times[$] - t_rel), 10);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during ROOT with 2 and 3 pending; 3 is in flight and is dropped.
    set_req(2, 20, 21);
    set_req(3, 12, 35);
    #1;
    check("t5_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("t5_in_root", 32'(busy), 1);
    n0 = rsp_ids.size();
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_valid", 32'(rsp_valid), 0);
    check("t5_rst_data", 32'(rsp_data), 0);
    check("t5_rst_id", 32'(rsp_id), 0);
    check("t5_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_regrant2", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    for (int i = 0; i < 40 && acc_ids[$] != 3; i++) @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (14) @(negedge clk);
    check("t5_rsp_count", 32'(rsp_ids.size() - n0), 2);
    if (rsp_ids.size() == n0 + 2) begin
      check("t5_rsp_first", 32'(rsp_ids[n0]), 2);
      check("t5_rsp_second", 32'(rsp_ids[n0+1]), 3);
    end

    // Randomised traffic with random stalls; the scoreboard checks each result.
    n0 = acc_ids.size();
    acc_pending = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid   = req_valid & ~acc_pending;
      acc_pending = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0)
            set_req(i, ($urandom_range(7) == 0) ? 255 : int'($urandom_range(255)),
                       ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255)));
        end else if (!req_ready[i] && $urandom_range(31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rnd_activity", 32'(acc_ids.size() - n0 >= 40), 1);
    check("rnd_drained", 32'(exp_q.size()), 0);
    check("rnd_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hypot_sched.md
# hypot_sched

Shared-magnitude scheduler: accepts (x, y) operand pairs from NREQ requesters, arbitrates round-robin, and sequences one shared iterative datapath that computes floor(sqrt(x*x + y*y)) one result bit per cycle. It sits between the requesting front-ends and the output register stage. It replaces per-requester combinational square-root logic with a single multi-cycle unit. Results return on one valid/ready response channel tagged with the requester index.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width (unsigned)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_x  in  NREQ*W  packed x operands; requester i uses bits [i*W +: W]
- req_y  in  NREQ*W  packed y operands, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  W+1  floor(sqrt(x^2+y^2)); 9 bits for W=8, max 360
- rsp_id  out  clog2(NREQ)  index of requester that owns rsp_data
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, SQUARE, ROOT, DONE.
- IDLE: req_ready is combinational and one-hot. It is given to the first requester with req_valid high, searching from rr_ptr upward modulo NREQ. It is all-zero if none is valid or state != IDLE.
- Accept means req_valid[i] & req_ready[i] at a clock edge. On accept:
  - latch x, y and id = i;
  - set rr_ptr = (i+1) mod NREQ;
  - go to SQUARE.
- SQUARE (1 cycle): sum = x*x + y*y. Register it at 2W+1 bits (17), which cannot overflow. Clear the result register, set bit index k = W, go to ROOT.
- ROOT (W+1 cycles, k = W down to 0):
  - trial = res | (1<<k);
  - if trial*trial <= sum, then res = trial;
  - the trial square is computed at 2W+2 bits (18), with no truncation;
  - after k = 0, load rsp_data = res and rsp_id = id, assert rsp_valid, go to DONE.
- DONE: hold rsp_valid, rsp_data and rsp_id stable until rsp_ready is high at an edge. Then deassert rsp_valid and go to IDLE.
- No request is accepted outside IDLE. Requesters hold req_valid and their operands until they are granted.
- A requester dropping req_valid before it is granted is legal. Such a requester is simply skipped.
- Operand changes after accept have no effect on the result.

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, rr_ptr 0, internal operands and sum 0.
- Latency: if accept is at edge E0, rsp_valid is high after edge E0+10 (1 SQUARE + 9 ROOT cycles for W=8; in general W+2 edges).
- Minimum spacing between accepts is 12 cycles with rsp_ready tied high:
  - accept edge;
  - 10 compute edges;
  - DONE-to-IDLE edge;
  - IDLE then grants on the following edge.
- Backpressure: with rsp_ready low, DONE holds indefinitely. busy stays 1 and every req_ready stays 0.
- Reset mid-operation (any state): everything returns to reset values immediately. The in-flight request is dropped and no response is produced. Its requester still has req_valid high and competes again from rr_ptr 0.
- Simultaneous requests: only the round-robin winner is granted. The others are unaffected.
- Wrap-around: after requester NREQ-1 is granted, priority starts again at 0.
- Boundary results:
  - x = y = 0 gives 0;
  - x = 0, y = 255 gives 255;
  - x = y = 255 (sum 130050) gives 360.

## Test plan
- Reset, then req 0 with x=3, y=4 -> rsp_data=5, rsp_id=0, rsp_valid rises 10 cycles after the accept edge, busy high from accept until the DONE-to-IDLE edge.
- Single requester with (0,0), (255,255), (1,1), (0,255) -> results 0, 360, 1, 255 respectively.
- All four req_valid held high, rsp_ready=1, distinct operands -> grant order 0,1,2,3,0 with matching rsp_id; accepts 12 cycles apart.
- Hold rsp_ready low for 5 cycles in DONE -> rsp_valid/rsp_data/rsp_id stable, req_ready all 0; release -> IDLE next edge, next grant the following edge.
- Pulse rst during ROOT with requests 2 and 3 pending -> all outputs 0 immediately, no response for the aborted request, next grant goes to requester 2.
- Randomised x, y across all requesters with random rsp_ready stalls -> every response equals floor(sqrt(x^2+y^2)) with correct id and exactly one response per accept.
